decoder_stream: RTL and testbench

Sequential counterpart of the 3-to-2 priority encoder: accepts 2-bit codes (3 = a, 2 = b, 1 = c, 0 = none) over a valid/ready handshake, buffers them in a small FIFO, and replays each as a one-hot {a,b,c} pattern held for a fixed number of cycles. It sits at the consuming end of the encoder's output, rebuilding the line pattern the encoder compressed. The original bit pattern is recoverable only for one-hot inputs; encoding is lossy otherwise.

---
 rtl/decoder_stream_pkg.sv | 26 ++
 rtl/decoder_stream_if.sv | 26 ++
 rtl/decoder_stream_code_fifo.sv | 64 ++++++
 rtl/decoder_stream.sv | 132 +++++++++++++
 tb/tb_decoder_stream.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/decoder_stream_pkg.sv
// Shared types, code constants and the code-to-line decode used by decoder_stream.
package decoder_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [1:0] CODE_NONE = 2'd0;
  localparam logic [1:0] CODE_C    = 2'd1;
  localparam logic [1:0] CODE_B    = 2'd2;
  localparam logic [1:0] CODE_A    = 2'd3;

  // Returns {a,b,c}; CODE_NONE is a real symbol that decodes to all-zero lines.
  function automatic logic [2:0] decode3(input logic [1:0] code);
    logic [2:0] lines;
    case (code)
      CODE_A:  lines = 3'b100;
      CODE_B:  lines = 3'b010;
      CODE_C:  lines = 3'b001;
      default: lines = 3'b000;
    endcase
    return lines;
  endfunction

endpackage

// File: rtl/decoder_stream_if.sv
// Code input handshake and decoded-line outputs of decoder_stream, bundled for port lists.
interface decoder_stream_if #(
  parameter int DEPTH = 4
);
  localparam int FILL_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_code;
  logic              a;
  logic              b;
  logic              c;
  logic              out_strobe;
  logic              busy;
  logic [FILL_W-1:0] fill;

  modport master (
    output in_valid, in_code,
    input  in_ready, a, b, c, out_strobe, busy, fill
  );

  modport slave (
    input  in_valid, in_code,
    output in_ready, a, b, c, out_strobe, busy, fill
  );
endinterface

// File: rtl/decoder_stream_code_fifo.sv
// Synchronous FIFO for 2-bit codes; push is refused when full even if a pop coincides.
module code_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  logic [WIDTH-1:0]  mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [FILL_W-1:0] fill_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full      = (fill_r == FILL_FULL);
  assign empty     = (fill_r == '0);
  assign fill      = fill_r;
  assign dout      = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage array, written only on accepted pushes.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      fill_r   <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   fill_r <= fill_r + FILL_ONE;
        2'b01:   fill_r <= fill_r - FILL_ONE;
        default: fill_r <= fill_r;
      endcase
    end
  end

endmodule

// File: rtl/decoder_stream.sv
// Replays queued 2-bit codes as one-hot {a,b,c} line patterns, each held HOLD_CYCLES cycles.
module decoder_stream
  import decoder_stream_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  decoder_stream_if.slave  bus
);
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t                state_r;
  state_t                state_nxt;
  logic [CNT_W-1:0]      hold_cnt_r;
  logic [CNT_W-1:0]      hold_cnt_nxt;
  logic [2:0]            lines_r;
  logic [2:0]            lines_nxt;
  logic                  strobe_r;
  logic                  strobe_nxt;
  logic                  busy_r;
  logic                  pop_s;
  logic [1:0]            fifo_dout_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [$clog2(DEPTH):0] fifo_fill_s;

  code_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid),
    .pop   (pop_s),
    .din   (bus.in_code),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .fill  (fifo_fill_s)
  );

  assign bus.in_ready   = !fifo_full_s;
  assign bus.fill       = fifo_fill_s;
  assign bus.a          = lines_r[2];
  assign bus.b          = lines_r[1];
  assign bus.c          = lines_r[0];
  assign bus.out_strobe = strobe_r;
  assign bus.busy       = busy_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic: leave HOLD only when the last cycle ends with nothing queued.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) state_nxt = HOLD;
        else               state_nxt = IDLE;
      end
      HOLD: begin
        if ((hold_cnt_r == '0) && fifo_empty_s) state_nxt = IDLE;
        else                                    state_nxt = HOLD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: pop and load a fresh symbol whenever the line slot is free.
  always_comb begin
    pop_s        = 1'b0;
    strobe_nxt   = 1'b0;
    lines_nxt    = lines_r;
    hold_cnt_nxt = hold_cnt_r;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s        = 1'b1;
          strobe_nxt   = 1'b1;
          lines_nxt    = decode3(fifo_dout_s);
          hold_cnt_nxt = HOLD_LOAD;
        end else begin
          lines_nxt    = 3'b000;
          hold_cnt_nxt = '0;
        end
      end
      HOLD: begin
        if (hold_cnt_r != '0) begin
          hold_cnt_nxt = hold_cnt_r - CNT_ONE;
        end else if (!fifo_empty_s) begin
          pop_s        = 1'b1;
          strobe_nxt   = 1'b1;
          lines_nxt    = decode3(fifo_dout_s);
          hold_cnt_nxt = HOLD_LOAD;
        end else begin
          lines_nxt    = 3'b000;
          hold_cnt_nxt = '0;
        end
      end
      default: begin
        lines_nxt    = 3'b000;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  // Registered line, strobe, busy and hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      lines_r    <= 3'b000;
      strobe_r   <= 1'b0;
      busy_r     <= 1'b0;
      hold_cnt_r <= '0;
    end else begin
      lines_r    <= lines_nxt;
      strobe_r   <= strobe_nxt;
      busy_r     <= (state_nxt == HOLD);
      hold_cnt_r <= hold_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_decoder_stream.sv
// Self-checking bench: two decoder_stream instances (HOLD_CYCLES 4 and 1) on shared stimulus.
module tb_decoder_stream;
  import decoder_stream_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_code;

  always #5 clk = ~clk;

  decoder_stream_if #(.DEPTH(DEPTH)) bus4 ();
  decoder_stream_if #(.DEPTH(DEPTH)) bus1 ();

  assign bus4.in_valid = in_valid;
  assign bus4.in_code  = in_code;
  assign bus1.in_valid = in_valid;
  assign bus1.in_code  = in_code;

  decoder_stream #(.DEPTH(DEPTH), .HOLD_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  decoder_stream #(.DEPTH(DEPTH), .HOLD_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int tests = 0;
  int fails = 0;

  // Reference model: a queue of codes plus "cycles left on the current symbol".
  logic [1:0] mbuf [2][32];
  int         mhead [2];
  int         msize [2];
  int         mrem  [2];
  logic [2:0] mpat  [2];
  logic       mstb  [2];

  typedef struct {
    logic       r;
    logic       v;
    logic [1:0] code;
    logic [8:0] exp;
  } vec_t;

  vec_t       vecs [8];
  logic [2:0] obs_pat  [20];
  logic       obs_stb  [20];
  logic       obs_busy [20];

  function automatic logic [2:0] ref_decode(input logic [1:0] code);
    int sh;
    sh = int'(code);
    if (sh == 0) return 3'b000;
    return 3'(1 << (sh - 1));
  endfunction

  function automatic logic [31:0] dut_vec(input int i);
    if (i == 0)
      return {23'd0, bus4.a, bus4.b, bus4.c, bus4.out_strobe, bus4.busy, bus4.in_ready, bus4.fill};
    return {23'd0, bus1.a, bus1.b, bus1.c, bus1.out_strobe, bus1.busy, bus1.in_ready, bus1.fill};
  endfunction

  function automatic logic [31:0] model_vec(input int i);
    logic bz;
    logic rdy;
    bz  = (mrem[i] > 0) ? 1'b1 : 1'b0;
    rdy = (msize[i] < DEPTH) ? 1'b1 : 1'b0;
    return {23'd0, mpat[i], mstb[i], bz, rdy, 3'(msize[i])};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input int hold, input logic r, input logic v,
                            input logic [1:0] code);
    logic acc;
    if (r) begin
      mhead[i] = 0; msize[i] = 0; mrem[i] = 0; mpat[i] = 3'b000; mstb[i] = 1'b0;
      return;
    end
    acc = v && (msize[i] < DEPTH);
    if (mrem[i] > 1) begin
      mrem[i]--;
      mstb[i] = 1'b0;
    end else if (msize[i] > 0) begin
      mpat[i]  = ref_decode(mbuf[i][mhead[i]]);
      mhead[i] = (mhead[i] + 1) % 32;
      msize[i]--;
      mrem[i]  = hold;
      mstb[i]  = 1'b1;
    end else begin
      mrem[i] = 0; mpat[i] = 3'b000; mstb[i] = 1'b0;
    end
    if (acc) begin
      mbuf[i][(mhead[i] + msize[i]) % 32] = code;
      msize[i]++;
    end
  endtask

  // One clock: drive, advance model on the edge, compare both instances 1 time unit later.
  task automatic cycle(input logic r, input logic v, input logic [1:0] code);
    rst = r; in_valid = v; in_code = code;
    @(posedge clk);
    model_step(0, 4, r, v, code);
    model_step(1, 1, r, v, code);
    #1;
    check("model_h4", dut_vec(0), model_vec(0));
    check("model_h1", dut_vec(1), model_vec(1));
  endtask

  initial begin
    int acc_cnt;
    int nstb;
    bit found;
    logic [1:0] hc [8];

    rst = 1'b1; in_valid = 1'b0; in_code = CODE_NONE;
    for (int i = 0; i < 2; i++) begin
      mhead[i] = 0; msize[i] = 0; mrem[i] = 0; mpat[i] = 3'b000; mstb[i] = 1'b0;
    end

    // Reset then idle.
    cycle(1'b1, 1'b0, 2'd0);
    cycle(1'b1, 1'b0, 2'd0);
    check("reset_h4", dut_vec(0), 32'h008);
    check("reset_h1", dut_vec(1), 32'h008);
    nstb = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b0, 2'd0);
      nstb += int'(bus4.out_strobe) + int'(bus1.out_strobe);
    end
    check("idle_no_strobe", 32'(nstb), 32'd0);

    // Single code 3 on the HOLD_CYCLES=4 instance.
    vecs[0] = '{1'b1, 1'b0, 2'd0, 9'b000_0_0_1_000};
    vecs[1] = '{1'b0, 1'b1, 2'd3, 9'b000_0_0_1_001};
    vecs[2] = '{1'b0, 1'b0, 2'd0, 9'b100_1_1_1_000};
    vecs[3] = '{1'b0, 1'b0, 2'd0, 9'b100_0_1_1_000};
    vecs[4] = '{1'b0, 1'b0, 2'd0, 9'b100_0_1_1_000};
    vecs[5] = '{1'b0, 1'b0, 2'd0, 9'b100_0_1_1_000};
    vecs[6] = '{1'b0, 1'b0, 2'd0, 9'b000_0_0_1_000};
    vecs[7] = '{1'b0, 1'b0, 2'd0, 9'b000_0_0_1_000};
    for (int k = 0; k < 8; k++) begin
      cycle(vecs[k].r, vecs[k].v, vecs[k].code);
      check($sformatf("vec%0d", k), dut_vec(0), {23'd0, vecs[k].exp});
    end

    // Burst 3,2,1,0 on consecutive cycles.
    for (int e = 0; e < 20; e++) begin
      if (e < 4) begin
        check($sformatf("burst_ready%0d", e), {31'd0, bus4.in_ready}, 32'd1);
        cycle(1'b0, 1'b1, 2'(3 - e));
      end else begin
        cycle(1'b0, 1'b0, 2'd0);
      end
      obs_pat[e]  = {bus4.a, bus4.b, bus4.c};
      obs_stb[e]  = bus4.out_strobe;
      obs_busy[e] = bus4.busy;
    end
    nstb = 0;
    for (int e = 1; e <= 16; e++) begin
      check($sformatf("burst_pat%0d", e), {29'd0, obs_pat[e]}, {29'd0, ref_decode(2'(3 - (e - 1) / 4))});
      check($sformatf("burst_stb%0d", e), {31'd0, obs_stb[e]}, {31'd0, ((e - 1) % 4 == 0)});
      nstb += int'(obs_stb[e]);
    end
    check("burst_strobes", 32'(nstb), 32'd4);
    check("burst_busy_last", {31'd0, obs_busy[16]}, 32'd1);
    check("burst_idle_after", {28'd0, obs_busy[17], obs_pat[17]}, 32'd0);

    // Fill to full while holding; extra push refused even with a coinciding pop.
    acc_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus4.in_ready == 1'b0) break;
      cycle(1'b0, 1'b1, 2'd2);
      acc_cnt++;
    end
    check("full_accepted", 32'(acc_cnt), 32'd5);
    check("full_fill", {29'd0, bus4.fill}, 32'd4);
    check("full_ready", {31'd0, bus4.in_ready}, 32'd0);
    cycle(1'b0, 1'b1, 2'd1);
    check("full_pop_fill", {29'd0, bus4.fill}, 32'd3);
    check("full_pop_ready", {30'd0, bus4.in_ready, bus4.out_strobe}, 32'd3);

    // Reset mid-HOLD with two entries queued.
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle(1'b0, 1'b0, 2'd0);
      if (bus4.fill == 3'd2) found = 1'b1;
    end
    check("midrst_reached", {31'd0, found}, 32'd1);
    check("midrst_busy", {31'd0, bus4.busy}, 32'd1);
    cycle(1'b1, 1'b0, 2'd0);
    check("midrst_state", dut_vec(0), 32'h008);
    nstb = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 1'b0, 2'd0);
      nstb += int'(bus4.out_strobe);
    end
    check("midrst_no_replay", 32'(nstb), 32'd0);

    // HOLD_CYCLES=1: alternating 1/2 stream with in_valid held high.
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        hc[k] = (k % 2 == 0) ? CODE_C : CODE_B;
        check($sformatf("h1_ready%0d", k), {31'd0, bus1.in_ready}, 32'd1);
        cycle(1'b0, 1'b1, hc[k]);
      end else begin
        cycle(1'b0, 1'b0, 2'd0);
      end
      if (k >= 1 && k <= 8) begin
        check($sformatf("h1_stb%0d", k), {31'd0, bus1.out_strobe}, 32'd1);
        check($sformatf("h1_pat%0d", k), {29'd0, bus1.a, bus1.b, bus1.c}, {29'd0, ref_decode(hc[k - 1])});
      end
    end
    check("h1_stb_end", {31'd0, bus1.out_strobe}, 32'd0);
    for (int k = 0; k < 30; k++) cycle(1'b0, 1'b0, 2'd0);

    // Randomized traffic with occasional resets, checked against the model every cycle.
    for (int k = 0; k < 800; k++) begin
      cycle(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
            2'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
